// File: rtl/sd_arb_pkg.sv
// Shared types for the SD SPI arbiter: FSM state encoding and the downstream
// SPI command bundle.
package sd_arb_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              rst_spi;
    logic              r_block;
    logic              r_multi_block;
    logic              r_byte;
    logic [ADDR_W-1:0] block_addr;
  } spi_cmd_t;

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear and count enable.
module counter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/rr_priority_enc.sv
// Round-robin priority encoder: picks the first set request bit scanning
// upward from last+1, wrapping around.
module rr_priority_enc #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Scan farthest-to-nearest so the nearest set bit is the final assignment.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % N_REQ]) begin
        valid = 1'b1;
        index = IDX_W'((int'(last) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/sd_spi_arbiter.sv
// Shares one SD SPI controller among N_REQ requesters with round-robin grant,
// a post-release drain phase and an optional hold watchdog.
module sd_spi_arbiter
  import sd_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int MAX_HOLD = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           gnt,
  input  logic [N_REQ-1:0]           m_rst_spi,
  input  logic [N_REQ-1:0]           m_r_block,
  input  logic [N_REQ-1:0]           m_r_multi_block,
  input  logic [N_REQ-1:0]           m_r_byte,
  input  logic [N_REQ*ADDR_W-1:0]    m_block_addr,
  output logic [N_REQ-1:0]           m_spi_busy,
  output logic [N_REQ-1:0]           m_spi_err,
  output logic [7:0]                 m_spi_data,
  output logic                       rst_spi,
  output logic                       r_block,
  output logic                       r_multi_block,
  output logic                       r_byte,
  output logic [ADDR_W-1:0]          block_addr,
  input  logic                       spi_busy,
  input  logic                       spi_err,
  input  logic [7:0]                 spi_data,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       timeout
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e       state;
  logic [N_REQ-1:0] revoked;
  logic [N_REQ-1:0] eligible;
  logic [31:0]      hold_cnt;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             owner_req;
  logic             wd_expire;
  spi_cmd_t         owner_cmd;
  spi_cmd_t         down_cmd;

  // A revoked requester stays ineligible until it has dropped req once.
  assign eligible  = req & ~revoked;
  assign owner_req = req[owner];
  assign wd_expire = (MAX_HOLD != 0) && (hold_cnt == 32'(MAX_HOLD - 1));

  rr_priority_enc #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (eligible),
    .last  (owner),
    .valid (sel_valid),
    .index (sel_idx)
  );

  counter #(
    .DATA_WIDTH (32)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state == ST_IDLE) && sel_valid),
    .en    (state == ST_GRANT),
    .count (hold_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      owner   <= IDX_W'(N_REQ - 1);
      revoked <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i]) revoked[i] <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            state <= ST_GRANT;
            owner <= sel_idx;
            gnt   <= N_REQ'(1) << sel_idx;
          end
        end
        ST_GRANT: begin
          // A release in the expiry cycle wins over the watchdog.
          if (!owner_req) begin
            state <= ST_DRAIN;
            gnt   <= '0;
          end else if (wd_expire) begin
            state          <= ST_DRAIN;
            gnt            <= '0;
            timeout        <= 1'b1;
            revoked[owner] <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!spi_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    owner_cmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(owner) == i) begin
        owner_cmd.rst_spi       = m_rst_spi[i];
        owner_cmd.r_block       = m_r_block[i];
        owner_cmd.r_multi_block = m_r_multi_block[i];
        owner_cmd.r_byte        = m_r_byte[i];
        owner_cmd.block_addr    = m_block_addr[ADDR_W*i +: ADDR_W];
      end
    end
    down_cmd = (state == ST_GRANT) ? owner_cmd : '0;
  end

  assign rst_spi       = down_cmd.rst_spi;
  assign r_block       = down_cmd.r_block;
  assign r_multi_block = down_cmd.r_multi_block;
  assign r_byte        = down_cmd.r_byte;
  assign block_addr    = down_cmd.block_addr;
  assign m_spi_data    = spi_data;

  // Non-owners always see the controller as busy.
  always_comb begin
    m_spi_busy = '1;
    m_spi_err  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(owner) == i) begin
        if (state == ST_GRANT) m_spi_busy[i] = spi_busy;
        m_spi_err[i] = ((state == ST_GRANT) && spi_err) || revoked[i];
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Directed bench for sd_spi_arbiter: one instance without watchdog, one with
// MAX_HOLD=100, sharing the controller-side inputs.
module tb_sd_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0, req_wd = '0;
  logic [1:0]  m_rst_spi = '0, m_r_block = '0, m_r_multi_block = '0, m_r_byte = '0;
  logic [63:0] m_block_addr = '0;
  logic        spi_busy = 1'b0, spi_err = 1'b0;
  logic [7:0]  spi_data = '0;

  logic [1:0]  gnt, m_spi_busy, m_spi_err;
  logic [7:0]  m_spi_data;
  logic        rst_spi, r_block, r_multi_block, r_byte, owner, timeout;
  logic [31:0] block_addr;

  logic [1:0]  gnt_wd, m_spi_busy_wd, m_spi_err_wd;
  logic [7:0]  m_spi_data_wd;
  logic        rst_spi_wd, r_block_wd, r_multi_block_wd, r_byte_wd, owner_wd, timeout_wd;
  logic [31:0] block_addr_wd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sd_spi_arbiter #(.N_REQ(2), .MAX_HOLD(0)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .m_rst_spi(m_rst_spi), .m_r_block(m_r_block), .m_r_multi_block(m_r_multi_block),
    .m_r_byte(m_r_byte), .m_block_addr(m_block_addr),
    .m_spi_busy(m_spi_busy), .m_spi_err(m_spi_err), .m_spi_data(m_spi_data),
    .rst_spi(rst_spi), .r_block(r_block), .r_multi_block(r_multi_block), .r_byte(r_byte),
    .block_addr(block_addr), .spi_busy(spi_busy), .spi_err(spi_err), .spi_data(spi_data),
    .owner(owner), .timeout(timeout)
  );

  sd_spi_arbiter #(.N_REQ(2), .MAX_HOLD(100)) dut_wd (
    .clk(clk), .rst(rst), .req(req_wd), .gnt(gnt_wd),
    .m_rst_spi(m_rst_spi), .m_r_block(m_r_block), .m_r_multi_block(m_r_multi_block),
    .m_r_byte(m_r_byte), .m_block_addr(m_block_addr),
    .m_spi_busy(m_spi_busy_wd), .m_spi_err(m_spi_err_wd), .m_spi_data(m_spi_data_wd),
    .rst_spi(rst_spi_wd), .r_block(r_block_wd), .r_multi_block(r_multi_block_wd),
    .r_byte(r_byte_wd), .block_addr(block_addr_wd), .spi_busy(spi_busy), .spi_err(spi_err),
    .spi_data(spi_data), .owner(owner_wd), .timeout(timeout_wd)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req = '0; req_wd = '0; spi_busy = 1'b0; spi_err = 1'b0;
    m_rst_spi = '0; m_r_block = '0; m_r_multi_block = '0; m_r_byte = '0;
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    m_rst_spi = 2'b11; m_r_block = 2'b11; m_r_multi_block = 2'b11; m_r_byte = 2'b11;
    m_block_addr = '1; req = 2'b11; spi_busy = 1'b0;
    #1 rst = 1'b0;
    #2;
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    tests++; if (owner !== 1'b1) begin fails++; $display("FAIL reset_owner: got %b want 1", owner); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    tests++; if ({rst_spi, r_block, r_multi_block, r_byte} !== 4'b0000) begin
      fails++; $display("FAIL reset_cmds: got %b want 0000", {rst_spi, r_block, r_multi_block, r_byte}); end
    tests++; if (block_addr !== 32'd0) begin fails++; $display("FAIL reset_addr: got %h want 0", block_addr); end
    tests++; if (m_spi_busy !== 2'b11) begin fails++; $display("FAIL reset_busy: got %b want 11", m_spi_busy); end
    tests++; if (m_spi_err !== 2'b00) begin fails++; $display("FAIL reset_err: got %b want 00", m_spi_err); end
    tests++; if (gnt_wd !== 2'b00 || owner_wd !== 1'b1) begin
      fails++; $display("FAIL reset_wd: got gnt %b owner %b want 00 1", gnt_wd, owner_wd); end
    cyc();
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_hold_gnt: got %b want 00", gnt); end
    m_rst_spi = '0; m_r_block = '0; m_r_multi_block = '0; m_r_byte = '0;
    m_block_addr = '0; req = '0;
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_single_grant();
    int bad;
    req = 2'b01; m_block_addr = {32'h0000_2222, 32'h0000_1111}; m_r_block = 2'b01; spi_busy = 1'b1;
    #1;
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL single_latency: got %b want 00", gnt); end
    cyc();
    tests++; if (gnt !== 2'b01 || owner !== 1'b0) begin
      fails++; $display("FAIL single_gnt: got gnt %b owner %b want 01 0", gnt, owner); end
    tests++; if (block_addr !== 32'h0000_1111) begin
      fails++; $display("FAIL single_addr: got %h want 00001111", block_addr); end
    tests++; if (r_block !== 1'b1 || r_multi_block !== 1'b0) begin
      fails++; $display("FAIL single_cmd: got r_block %b r_multi %b want 1 0", r_block, r_multi_block); end
    tests++; if (m_spi_busy !== 2'b11) begin fails++; $display("FAIL single_busy_hi: got %b want 11", m_spi_busy); end
    spi_busy = 1'b0; #1;
    tests++; if (m_spi_busy !== 2'b10) begin fails++; $display("FAIL single_busy_lo: got %b want 10", m_spi_busy); end
    bad = 0;
    repeat (300) begin
      cyc();
      spi_busy = ~spi_busy; #1;
      if (gnt !== 2'b01 || m_spi_busy[1] !== 1'b1 || m_spi_busy[0] !== spi_busy ||
          timeout !== 1'b0 || block_addr !== 32'h0000_1111) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL single_hold300: got %0d bad cycles want 0", bad); end
    req = 2'b00; spi_busy = 1'b0; m_r_block = 2'b00;
    cyc();
    tests++; if (gnt !== 2'b00 || block_addr !== 32'd0) begin
      fails++; $display("FAIL single_release: got gnt %b addr %h want 00 0", gnt, block_addr); end
    cyc(); cyc();
  endtask

  task automatic test_round_robin();
    apply_reset();
    req = 2'b11;
    cyc();
    tests++; if (gnt !== 2'b01 || owner !== 1'b0) begin
      fails++; $display("FAIL rr_first: got gnt %b owner %b want 01 0", gnt, owner); end
    repeat (3) cyc();
    tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL rr_nonowner_ignored: got %b want 01", gnt); end
    req = 2'b10;
    cyc();
    tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL rr_drain0: got %b want 00", gnt); end
    cyc(); cyc();
    tests++; if (gnt !== 2'b10 || owner !== 1'b1) begin
      fails++; $display("FAIL rr_second: got gnt %b owner %b want 10 1", gnt, owner); end
    req = 2'b11;
    repeat (2) cyc();
    tests++; if (gnt !== 2'b10) begin fails++; $display("FAIL rr_hold1: got %b want 10", gnt); end
    req = 2'b01;
    cyc(); cyc(); cyc();
    tests++; if (gnt !== 2'b01 || owner !== 1'b0) begin
      fails++; $display("FAIL rr_third: got gnt %b owner %b want 01 0", gnt, owner); end
  endtask

  task automatic test_drain();
    int zero, cmd_bad;
    bit granted;
    m_r_multi_block = 2'b01; m_r_byte = 2'b01; #1;
    tests++; if (r_multi_block !== 1'b1 || r_byte !== 1'b1) begin
      fails++; $display("FAIL drain_pre_cmd: got %b%b want 11", r_multi_block, r_byte); end
    req = 2'b11; spi_busy = 1'b1;
    cyc();
    req = 2'b10;
    zero = 0; cmd_bad = 0; granted = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (gnt !== 2'b00) begin granted = 1'b1; break; end
      zero++;
      if ({rst_spi, r_block, r_multi_block, r_byte} !== 4'b0000 || block_addr !== 32'd0 ||
          m_spi_busy !== 2'b11) cmd_bad++;
      if (zero == 5) spi_busy = 1'b0;
    end
    tests++; if (!granted) begin fails++; $display("FAIL drain_regrant_timeout: got none want grant"); end
    tests++; if (zero != 6) begin fails++; $display("FAIL drain_length: got %0d idle cycles want 6", zero); end
    tests++; if (cmd_bad != 0) begin fails++; $display("FAIL drain_cmds_zero: got %0d bad want 0", cmd_bad); end
    tests++; if (gnt !== 2'b10 || owner !== 1'b1) begin
      fails++; $display("FAIL drain_next: got gnt %b owner %b want 10 1", gnt, owner); end
    m_r_multi_block = 2'b00; m_r_byte = 2'b00;
  endtask

  task automatic test_block_addr();
    m_block_addr[63:32] = 32'd50; spi_data = 8'hA5; spi_err = 1'b1; spi_busy = 1'b0;
    #1;
    tests++; if (block_addr !== 32'd50) begin fails++; $display("FAIL addr_owner1: got %0d want 50", block_addr); end
    tests++; if (m_spi_data !== 8'hA5 || m_spi_data_wd !== 8'hA5) begin
      fails++; $display("FAIL data_bcast: got %h %h want a5", m_spi_data, m_spi_data_wd); end
    tests++; if (m_spi_err !== 2'b10) begin fails++; $display("FAIL err_owner1: got %b want 10", m_spi_err); end
    tests++; if (m_spi_busy !== 2'b01) begin fails++; $display("FAIL busy_owner1: got %b want 01", m_spi_busy); end
    req = 2'b00; spi_err = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_watchdog();
    int bad;
    apply_reset();
    req_wd = 2'b01;
    cyc();
    tests++; if (gnt_wd !== 2'b01) begin fails++; $display("FAIL wd_grant: got %b want 01", gnt_wd); end
    bad = 0;
    repeat (99) begin
      cyc();
      if (gnt_wd !== 2'b01 || timeout_wd !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL wd_early: got %0d bad cycles want 0", bad); end
    cyc();
    tests++; if (timeout_wd !== 1'b1 || gnt_wd !== 2'b00) begin
      fails++; $display("FAIL wd_expire: got timeout %b gnt %b want 1 00", timeout_wd, gnt_wd); end
    tests++; if (m_spi_err_wd !== 2'b01) begin fails++; $display("FAIL wd_err: got %b want 01", m_spi_err_wd); end
    cyc();
    tests++; if (timeout_wd !== 1'b0) begin fails++; $display("FAIL wd_pulse: got %b want 0", timeout_wd); end
    bad = 0;
    repeat (10) begin
      cyc();
      if (gnt_wd !== 2'b00 || m_spi_err_wd !== 2'b01) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL wd_no_regrant: got %0d bad cycles want 0", bad); end
    req_wd = 2'b00;
    cyc();
    tests++; if (m_spi_err_wd !== 2'b00) begin fails++; $display("FAIL wd_err_clear: got %b want 00", m_spi_err_wd); end
    req_wd = 2'b01;
    cyc();
    tests++; if (gnt_wd !== 2'b01) begin fails++; $display("FAIL wd_regrant: got %b want 01", gnt_wd); end
    repeat (99) cyc();
    req_wd = 2'b00;
    cyc();
    tests++; if (timeout_wd !== 1'b0 || gnt_wd !== 2'b00 || m_spi_err_wd !== 2'b00) begin
      fails++; $display("FAIL wd_drop_wins: got timeout %b gnt %b err %b want 0 00 00",
                        timeout_wd, gnt_wd, m_spi_err_wd); end
    cyc();
    tests++; if (timeout_wd !== 1'b0) begin fails++; $display("FAIL wd_drop_late: got %b want 0", timeout_wd); end
  endtask

  task automatic test_reset_mid();
    req = 2'b01; m_r_multi_block = 2'b01; spi_busy = 1'b1;
    cyc(); #1;
    tests++; if (gnt !== 2'b01 || r_multi_block !== 1'b1) begin
      fails++; $display("FAIL mid_pre: got gnt %b rmb %b want 01 1", gnt, r_multi_block); end
    #2 rst = 1'b0;
    #1;
    tests++; if (gnt !== 2'b00 || r_multi_block !== 1'b0) begin
      fails++; $display("FAIL mid_reset: got gnt %b rmb %b want 00 0", gnt, r_multi_block); end
    tests++; if (owner !== 1'b1 || m_spi_busy !== 2'b11) begin
      fails++; $display("FAIL mid_reset_state: got owner %b busy %b want 1 11", owner, m_spi_busy); end
    req = 2'b00; spi_busy = 1'b0; m_r_multi_block = 2'b00;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_drain();
    test_block_addr();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

endmodule

// File: doc/sd_spi_arbiter.md
SD_SPI_ARBITER -- requirements
Module: sd_spi_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters sharing one SD SPI controller (2..8).
REQ-002 Parameter MAX_HOLD, default 0: maximum grant length in clk cycles; 0 disables the watchdog.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 req  in  N_REQ  per-requester access request, level, held for the whole transaction.
REQ-006 gnt  out  N_REQ  one-hot grant, registered.
REQ-007 m_rst_spi, m_r_block, m_r_multi_block, m_r_byte  in  N_REQ each  per-requester SPI commands.
REQ-008 m_block_addr  in  N_REQ*32  per-requester block address; requester i occupies bits [32i+31:32i].
REQ-009 m_spi_busy  out  N_REQ  per-requester busy view.
REQ-010 m_spi_err  out  N_REQ  per-requester error view.
REQ-011 m_spi_data  out  8  spi_data broadcast unmodified to all requesters.
REQ-012 rst_spi, r_block, r_multi_block, r_byte  out  1 each  commands to the SPI controller.
REQ-013 block_addr  out  32  address to the SPI controller.
REQ-014 spi_busy, spi_err  in  1 each; spi_data  in  8: status and data from the SPI controller.
REQ-015 owner  out  $clog2(N_REQ)  index of the current or last owner.
REQ-016 timeout  out  1  one-cycle pulse when the watchdog revokes a grant.

Function
REQ-017 The FSM SHALL have three states, IDLE, GRANT and DRAIN, encoded in a shared enum.
REQ-018 In IDLE, with any req bit set, the arbiter SHALL select the first set bit scanning round-robin from owner+1, load owner, and enter GRANT; gnt goes high on the next edge (1-cycle grant latency).
REQ-019 In GRANT, the downstream commands and block_addr SHALL combinationally equal the owner's inputs.
REQ-020 m_spi_busy[owner] SHALL equal spi_busy; every other m_spi_busy bit SHALL be 1.
REQ-021 m_spi_err[owner] SHALL equal spi_err; every other m_spi_err bit SHALL be 0.
REQ-022 In IDLE and DRAIN, all downstream commands and block_addr SHALL be 0, and all m_spi_busy bits SHALL be 1.
REQ-023 In GRANT, when req[owner]=0 is sampled, the arbiter SHALL clear gnt and enter DRAIN; requests from non-owners SHALL have no effect during GRANT.
REQ-024 DRAIN SHALL last at least one cycle and SHALL return to IDLE on the first cycle in which spi_busy=0, so that the multi-block read terminates before the next owner is granted.
REQ-025 A 32-bit hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-026 If MAX_HOLD!=0 and the hold counter equals MAX_HOLD-1, the arbiter SHALL pulse timeout, enter DRAIN, and latch a revoked flag for the owner.
REQ-027 While the revoked flag is set, m_spi_err[owner] SHALL be 1; the flag clears when req[owner]=0 is sampled.
REQ-028 A revoked requester whose req is still high SHALL NOT be re-granted until it has dropped req for at least one cycle.
REQ-029 If the owner's req drops in the same cycle as the watchdog expires, the drop SHALL take precedence: no timeout pulse and no revoked flag.
REQ-030 Simultaneous requests SHALL be granted strictly round-robin; no requester waits more than N_REQ-1 grants.

Reset
REQ-031 When rst is low, the arbiter SHALL immediately force state=IDLE, gnt=0, owner=N_REQ-1 (requester 0 first), hold counter=0, revoked flags=0 and timeout=0, and downstream outputs SHALL follow REQ-022.
REQ-032 Reset asserted mid-transaction SHALL drop the grant without a DRAIN phase; the requester is responsible for re-issuing rst_spi.

Structure
REQ-033 The package sd_arb_pkg SHALL hold the state enum, the SPI command struct (rst_spi, r_block, r_multi_block, r_byte, block_addr) and the 32-bit address width constant.
REQ-034 Round-robin selection SHALL be a single sub-module, rr_priority_enc (inputs: request vector, last index; outputs: valid, index).
REQ-035 The hold counter SHALL reuse the existing counter module with DATA_WIDTH=32.

Verification
REQ-036 req=2'b01, hold 300 cycles -> gnt=01 one cycle later; block_addr=requester-0 address; m_spi_busy[1]=1 throughout.
REQ-037 req=2'b11 from reset -> requester 0 granted first; after it releases and spi_busy=0, requester 1 granted; then requester 0 again.
REQ-038 Owner drops req while spi_busy=1 for 5 cycles -> DRAIN lasts 5 cycles; all downstream commands are 0 during DRAIN.
REQ-039 MAX_HOLD=100, owner holds req -> timeout pulse at grant cycle 100; m_spi_err[owner]=1 until req drops; no re-grant while req stays high.
REQ-040 rst low during GRANT with r_multi_block=1 -> gnt=0 and r_multi_block=0 in the same cycle, without waiting for a clk edge.
REQ-041 m_block_addr[1]=32'd50, owner=1 -> block_addr=32'd50, and spi_data is visible on m_spi_data to both requesters.
